layer_sequencer: RTL
====================

Name: layer_sequencer

Overview:
Top-level layer scheduler for the CNN human-on-railway detection accelerator. Drives the 4-bit State bus consumed by clock_switch and the layer engines, and sequences CONV1_1 through FC with a start/done handshake per layer. Inserts a clock-settle gap after every state change so clock_switch can finish switching before the layer is started. In JUDGE, thresholds the FC score and reports the per-frame detection result.

Parameters:
STATE_DATAWIDTH, 4, width of State bus
SETTLE_CYCLES, 4, cycles between a State change and the layer_start pulse (clock-switch settle), valid range 1..15
SCORE_WIDTH, 16, width of signed fc_score
THRESHOLD, 16'sd0, detection threshold (signed)
FRAME_CNT_WIDTH, 16, width of frame_count
TIMEOUT_CYCLES, 1000000, watchdog limit per layer (WATCHDOG_EN only)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  frame start request, sampled in IDLE only
abort  in  1  synchronous abort, return to IDLE
layer_done  in  1  one-cycle pulse from the active layer engine
fc_score  in  SCORE_WIDTH  signed FC output, valid when State=JUDGE
State  out  STATE_DATAWIDTH  current layer state (to clock_switch and datapath)
layer_start  out  1  one-cycle pulse that starts the active layer
busy  out  1  high in states 2..12
done  out  1  one-cycle pulse at end of JUDGE
human_detected  out  1  registered result of the last completed frame
frame_count  out  FRAME_CNT_WIDTH  completed frames, wraps
timeout_err  out  1  sticky watchdog flag

Behaviour:
- State encoding:
  - RESET=0, IDLE=1
  - CONV1_1=2, CONV1_2=3, AVG_POOL1=4
  - CONV2_1=5, CONV2_2=6, AVG_POOL2=7
  - CONV3_1=8, CONV3_2=9, AVG_POOL3=10
  - FC=11, JUDGE=12
  - Codes 13..15 are illegal and go to IDLE on the next cycle.
- Reset (rst=0):
  - State=RESET.
  - All outputs 0, counters 0, human_detected=0.
- RESET to IDLE: unconditionally on the first clk edge after rst is released.
- IDLE: when start=1, go to CONV1_1 and load the settle counter with SETTLE_CYCLES. start is ignored in all other states.
- Compute states 2..11 run two sub-phases:
  - SETTLE: the counter decrements once per cycle. On the cycle it reaches 0, layer_start=1 for exactly that cycle and the sub-phase becomes WAIT. layer_start therefore goes high SETTLE_CYCLES cycles after State updates.
  - WAIT: when layer_done=1, advance to State+1 and reload the settle counter. layer_done is ignored during SETTLE and on the layer_start cycle itself.
- State 11 (FC) with layer_done: go to JUDGE. JUDGE has no settle or start phase.
- JUDGE, one cycle:
  - human_detected <= (fc_score > THRESHOLD), signed compare.
  - done=1 for that cycle.
  - frame_count increments, wrapping 2^FRAME_CNT_WIDTH-1 to 0.
  - Next state is IDLE.
- abort=1 in any state other than RESET:
  - Next state is IDLE.
  - No done pulse; human_detected and frame_count are unchanged; layer_start is suppressed.
  - abort takes priority over layer_done and start in the same cycle.
- Asynchronous reset mid-frame: immediate return to the reset values above. The frame is lost.
- State is registered and glitch-free; it changes only on clk edges.

Optional Feature:
WATCHDOG_EN.
- Defined:
  - A cycle counter runs during WAIT and clears on every State change.
  - If it reaches TIMEOUT_CYCLES without layer_done, timeout_err is set (sticky) and the next state is IDLE, with no done pulse.
  - timeout_err is cleared when start is accepted in IDLE.
- Undefined: no counter is instantiated, timeout_err is tied to 0, and WAIT waits indefinitely.

Test Plan:
- Release rst, then pulse start: State goes 0 to 1 to 2. layer_start is high exactly 4 cycles after State=2. busy=1.
- Full frame with layer_done pulsed 10 cycles after each layer_start and fc_score=16'sd25: State steps 2 through 12, then 1. done pulses once, human_detected=1, frame_count=1.
- fc_score=-16'sd3, and layer_done pulsed during SETTLE: the early pulse is ignored and State holds until a WAIT-phase layer_done. human_detected=0.
- abort and layer_done asserted together in CONV2_2 (State=6): State becomes 1, no done, frame_count unchanged. A following start restarts at State=2.
- Drive rst low while State=9: all outputs clear asynchronously before the next edge, and State=0.
- WATCHDOG_EN with TIMEOUT_CYCLES=50 and no layer_done in CONV1_1: after 50 WAIT cycles, timeout_err=1 and State=1. The next start clears timeout_err.

Source files
------------

// File: rtl/layer_sequencer.sv
// layer_sequencer: top-level layer scheduler for the CNN human-on-railway
// detection accelerator. Steps the State bus through CONV1_1..FC with a
// clock-settle gap and a start/done handshake per layer, then thresholds the
// FC score in JUDGE and reports the per-frame detection result.
// Optional feature: define WATCHDOG_EN to add a per-layer WAIT watchdog that
// raises a sticky timeout_err and abandons the frame.
module layer_sequencer #(
  parameter int                            STATE_DATAWIDTH = 4,
  parameter int                            SETTLE_CYCLES   = 4,
  parameter int                            SCORE_WIDTH     = 16,
  parameter logic signed [SCORE_WIDTH-1:0] THRESHOLD       = 16'sd0,
  parameter int                            FRAME_CNT_WIDTH = 16,
  parameter int                            TIMEOUT_CYCLES  = 1000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          layer_done,
  input  logic signed [SCORE_WIDTH-1:0] fc_score,
  output logic [STATE_DATAWIDTH-1:0]    State,
  output logic                          layer_start,
  output logic                          busy,
  output logic                          done,
  output logic                          human_detected,
  output logic [FRAME_CNT_WIDTH-1:0]    frame_count,
  output logic                          timeout_err
);

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_IDLE      = 4'd1,
    S_CONV1_1   = 4'd2,
    S_CONV1_2   = 4'd3,
    S_AVG_POOL1 = 4'd4,
    S_CONV2_1   = 4'd5,
    S_CONV2_2   = 4'd6,
    S_AVG_POOL2 = 4'd7,
    S_CONV3_1   = 4'd8,
    S_CONV3_2   = 4'd9,
    S_AVG_POOL3 = 4'd10,
    S_FC        = 4'd11,
    S_JUDGE     = 4'd12
  } state_e;

  // Sub-phase of a compute layer: waiting for clock_switch, then for the engine.
  typedef enum logic {
    PH_SETTLE = 1'b0,
    PH_WAIT   = 1'b1
  } phase_e;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  // Reject parameter values the counters cannot represent.
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 || TIMEOUT_CYCLES < 1 ||
      STATE_DATAWIDTH < 4) begin : g_bad_param
    $error("layer_sequencer: parameter out of range");
  end

  state_e                     state_q, state_d;
  phase_e                     phase_q, phase_d;
  logic [3:0]                 settle_q, settle_d;
  logic                       human_q, human_d;
  logic [FRAME_CNT_WIDTH-1:0] frames_q, frames_d;
  logic                       is_compute;

  assign is_compute = (state_q >= S_CONV1_1) && (state_q <= S_FC);

`ifdef WATCHDOG_EN
  localparam int                WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
`endif

  // Next-state and handshake outputs; abort overrides everything at the end.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    phase_d     = phase_q;
    settle_d    = settle_q;
    human_d     = human_q;
    frames_d    = frames_q;
    layer_start = 1'b0;
    done        = 1'b0;
`ifdef WATCHDOG_EN
    timeout_d   = timeout_q;
`endif

    case (state_q)
      S_RESET: state_d = S_IDLE;

      S_IDLE: begin
        if (start) begin
          state_d  = S_CONV1_1;
          phase_d  = PH_SETTLE;
          settle_d = SETTLE_LOAD;
`ifdef WATCHDOG_EN
          timeout_d = 1'b0;
`endif
        end
      end

      S_CONV1_1, S_CONV1_2, S_AVG_POOL1,
      S_CONV2_1, S_CONV2_2, S_AVG_POOL2,
      S_CONV3_1, S_CONV3_2, S_AVG_POOL3,
      S_FC: begin
        if (phase_q == PH_SETTLE) begin
          // layer_done is ignored here, including on the layer_start cycle.
          if (settle_q == 4'd0) begin
            layer_start = 1'b1;
            phase_d     = PH_WAIT;
          end else begin
            settle_d = settle_q - 4'd1;
          end
        end else if (layer_done) begin
          // FC + 1 is JUDGE, which simply ignores the settle load.
          state_d  = state_e'(state_q + 4'd1);
          phase_d  = PH_SETTLE;
          settle_d = SETTLE_LOAD;
        end
`ifdef WATCHDOG_EN
        else if (wd_q == WD_LIMIT) begin
          state_d   = S_IDLE;
          phase_d   = PH_SETTLE;
          timeout_d = 1'b1;
        end
`endif
      end

      S_JUDGE: begin
        human_d  = (fc_score > THRESHOLD);
        frames_d = frames_q + 1'b1;
        done     = 1'b1;
        state_d  = S_IDLE;
      end

      // Codes 13..15 recover to IDLE.
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_RESET)) begin
      state_d     = S_IDLE;
      phase_d     = PH_SETTLE;
      settle_d    = settle_q;
      human_d     = human_q;
      frames_d    = frames_q;
      layer_start = 1'b0;
      done        = 1'b0;
`ifdef WATCHDOG_EN
      timeout_d   = timeout_q;
`endif
    end
  end

  // Sequencer state, settle counter and frame result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_RESET;
      phase_q  <= PH_SETTLE;
      settle_q <= 4'd0;
      human_q  <= 1'b0;
      frames_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q  <= state_d;
      phase_q  <= phase_d;
      settle_q <= settle_d;
      human_q  <= human_d;
      frames_q <= frames_d;
    end
  end

`ifdef WATCHDOG_EN
  // WAIT-phase cycle counter; cleared whenever State changes or outside WAIT.
  always_comb begin
    wd_d = '0;
    if (is_compute && (phase_q == PH_WAIT) && (state_d == state_q)) begin
      wd_d = wd_q + 1'b1;
    end
  end

  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign State          = STATE_DATAWIDTH'(state_q);
  assign busy           = (state_q >= S_CONV1_1) && (state_q <= S_JUDGE);
  assign human_detected = human_q;
  assign frame_count    = frames_q;

endmodule
